// File: rtl/pl_down_timer_4b.sv
// Parallel-load down-counting timer with run-control FSM and cascadable terminal-zero flag.
// Optional auto-reload from a shadow register when PL_DOWN_TIMER_RELOAD_EN is defined.
module pl_down_timer_4b #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr_b,
   input  logic [WIDTH-1:0] in,
   input  logic             load,
   input  logic             cten,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] out,
   output logic             tz,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_EXPIRED = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             busy_q, done_q;
   logic             out_zero;

`ifdef PL_DOWN_TIMER_RELOAD_EN
   logic [WIDTH-1:0] shadow_q, shadow_d;
`endif

   assign out_zero = (out_q == '0);

   // State register; busy/done are registered decodes of the next state.
   always_ff @(posedge clk or negedge clr_b) begin
      if (!clr_b) begin
         state_q  <= S_IDLE;
         out_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef PL_DOWN_TIMER_RELOAD_EN
         shadow_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         busy_q   <= (state_d == S_RUN);
         done_q   <= (state_d == S_EXPIRED);
`ifdef PL_DOWN_TIMER_RELOAD_EN
         shadow_q <= shadow_d;
`endif
      end
   end

   // Next-state logic, priority load > stop > start > count.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
`ifdef PL_DOWN_TIMER_RELOAD_EN
      shadow_d = shadow_q;
`endif
      if (load) begin
         out_d = in;
`ifdef PL_DOWN_TIMER_RELOAD_EN
         shadow_d = in;
`endif
         if (start) begin
            state_d = S_RUN;
         end else if (state_q == S_EXPIRED) begin
            state_d = S_IDLE;
         end
      end else if (stop) begin
         if (state_q == S_RUN) begin
            state_d = S_IDLE;
         end
      end else if (start && (state_q != S_RUN)) begin
         state_d = S_RUN;
      end else if ((state_q == S_RUN) && cten) begin
         if (!out_zero) begin
            out_d = out_q - ONE;
         end else begin
`ifdef PL_DOWN_TIMER_RELOAD_EN
            out_d = shadow_q;
`else
            state_d = S_EXPIRED;
`endif
         end
      end
   end

   // Outputs: tz is combinational so a cascaded stage sees it in the same cycle.
   always_comb begin
      tz   = (state_q == S_RUN) && out_zero && cten && !load;
      out  = out_q;
      busy = busy_q;
      done = done_q;
   end

endmodule

// File: tb/tb_pl_down_timer_4b.sv
// Randomized and directed bench for pl_down_timer_4b against a behavioural timer model.
// Follows PL_DOWN_TIMER_RELOAD_EN to select the one-shot or auto-reload expectations.
module tb_pl_down_timer_4b;

   logic       clk = 1'b0;
   logic       clr_b = 1'b0;
   logic [3:0] din = '0;
   logic       load = 1'b0, cten = 1'b0, start = 1'b0, stop = 1'b0;
   logic [3:0] dout;
   logic       tz, busy, done;

   // Cascade pair: low stage counts every cycle, high stage is enabled by low.tz.
   logic       c_load = 1'b0, c_start = 1'b0, c_cten = 1'b0;
   logic [3:0] lo_out, hi_out;
   logic       lo_tz, lo_busy, lo_done, hi_tz, hi_busy, hi_done;
   logic [3:0] c_in = 4'd15;
   logic       c_stop = 1'b0;

   int checks = 0;
   int failures = 0;

   // Behavioural model: count value, running flag, expired flag, reload value.
   int m_out = 0;
   bit m_running = 0;
   bit m_expired = 0;
   int m_shadow = 0;

   int s_out;
   bit s_tz, s_busy, s_done;

   always #5 clk = ~clk;

   pl_down_timer_4b #(.WIDTH(4)) dut (
      .clk(clk), .clr_b(clr_b), .in(din), .load(load), .cten(cten),
      .start(start), .stop(stop), .out(dout), .tz(tz), .busy(busy), .done(done)
   );

   pl_down_timer_4b #(.WIDTH(4)) u_lo (
      .clk(clk), .clr_b(clr_b), .in(c_in), .load(c_load), .cten(c_cten),
      .start(c_start), .stop(c_stop), .out(lo_out), .tz(lo_tz), .busy(lo_busy), .done(lo_done)
   );

   pl_down_timer_4b #(.WIDTH(4)) u_hi (
      .clk(clk), .clr_b(clr_b), .in(c_in), .load(c_load), .cten(lo_tz),
      .start(c_start), .stop(c_stop), .out(hi_out), .tz(hi_tz), .busy(hi_busy), .done(hi_done)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_out = 0;
      m_running = 0;
      m_expired = 0;
      m_shadow = 0;
   endtask

   // One clock of the timer as described in words: load, then stop, then start, then count.
   task automatic model_step(input bit ld, input int v, input bit ct, input bit st, input bit sp);
      if (ld) begin
         m_out = v;
         m_shadow = v;
         if (st) begin
            m_running = 1;
            m_expired = 0;
         end else if (m_expired) begin
            m_expired = 0;
         end
      end else if (sp) begin
         m_running = 0;
      end else if (st && !m_running) begin
         m_running = 1;
         m_expired = 0;
      end else if (m_running && ct) begin
         if (m_out > 0) begin
            m_out = m_out - 1;
         end else begin
`ifdef PL_DOWN_TIMER_RELOAD_EN
            m_out = m_shadow;
`else
            m_running = 0;
            m_expired = 1;
`endif
         end
      end
   endtask

   // Drive one cycle from a falling edge, compare against the model, advance on the rising edge.
   task automatic tick(input bit ld, input int v, input bit ct, input bit st, input bit sp);
      bit exp_tz;
      load = ld; din = 4'(v); cten = ct; start = st; stop = sp;
      #1;
      s_out = int'(dout); s_tz = tz; s_busy = busy; s_done = done;
      exp_tz = m_running && (m_out == 0) && ct && !ld;
      chk("out", s_out, m_out);
      chk("busy", int'(s_busy), int'(m_running));
      chk("done", int'(s_done), int'(m_expired));
      chk("tz", int'(s_tz), int'(exp_tz));
      @(posedge clk);
      model_step(ld, v, ct, st, sp);
      @(negedge clk);
   endtask

   initial begin
      int errs;
      int first_hi_tz;
      int exp_hi_out;
      bit exp_lo_tz, exp_hi_tz;

      // Reset held: everything at zero even with count enable high.
      model_reset();
      cten = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out", int'(dout), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_tz", int'(tz), 0);
      @(negedge clk);
      clr_b = 1'b1;
      $display("reset hold checked");

      // Asynchronous reset in the middle of a count at out=5.
      tick(1, 7, 0, 1, 0);
      tick(0, 0, 1, 0, 0);
      tick(0, 0, 1, 0, 0);
      cten = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
      #1;
      chk("mid_out5", int'(dout), 5);
      #2;
      clr_b = 1'b0;
      #1;
      model_reset();
      chk("async_out", int'(dout), 0);
      chk("async_busy", int'(busy), 0);
      chk("async_done", int'(done), 0);
      chk("async_tz", int'(tz), 0);
      @(negedge clk);
      clr_b = 1'b1;
      $display("async reset mid-count checked");

`ifdef PL_DOWN_TIMER_RELOAD_EN
      // Auto-reload: 2,1,0 repeating, tz on every third enabled cycle.
      tick(1, 2, 0, 1, 0);
      for (int i = 0; i < 9; i++) begin
         tick(0, 0, 1, 0, 0);
         chk("reload_out", s_out, 2 - (i % 3));
         chk("reload_tz", int'(s_tz), (i % 3 == 2) ? 1 : 0);
         chk("reload_done", int'(s_done), 0);
      end
      tick(0, 0, 0, 0, 1);
      $display("auto-reload sequence checked");
`else
      // One-shot: 3,2,1,0 with tz on the fourth enabled cycle, then expired.
      tick(1, 3, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         tick(0, 0, 1, 0, 0);
         chk("oneshot_out", s_out, 3 - i);
         chk("oneshot_tz", int'(s_tz), (i == 3) ? 1 : 0);
      end
      tick(0, 0, 1, 0, 0);
      chk("expired_done", int'(s_done), 1);
      chk("expired_busy", int'(s_busy), 0);
      chk("expired_out", s_out, 0);
      chk("expired_tz", int'(s_tz), 0);
      tick(1, 1, 0, 0, 0);
      $display("one-shot sequence checked");
`endif

      // Priority: load beats count; stop beats start.
      tick(1, 4, 0, 1, 0);
      tick(1, 9, 1, 0, 0);
      chk("prio_before", s_out, 4);
      tick(0, 0, 0, 1, 1);
      chk("prio_loaded", s_out, 9);
      chk("prio_busy", int'(s_busy), 1);
      tick(0, 0, 1, 0, 0);
      chk("prio_stopped", int'(s_busy), 0);
      chk("prio_held", s_out, 9);
      $display("priority checked");

      // Gating: cten 1,0,1,0 from 6 gives 5,5,4,4; IDLE ignores cten.
      tick(1, 6, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         tick(0, 0, (i % 2 == 0), 0, 0);
      end
      tick(0, 0, 0, 0, 1);
      chk("gate_out", s_out, 4);
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 1, 0, 0);
         chk("idle_out", s_out, 4);
         chk("idle_tz", int'(s_tz), 0);
      end
      $display("gating checked");

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         tick($urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
              $urandom_range(0, 9) < 7, $urandom_range(0, 6) == 0,
              $urandom_range(0, 19) == 0);
      end
      $display("random traffic done");

      // Cascade: both stages loaded 15 and started together.
      c_load = 1'b1; c_start = 1'b1; c_cten = 1'b0;
      @(negedge clk);
      c_load = 1'b0; c_start = 1'b0; c_cten = 1'b1;
      errs = 0;
      first_hi_tz = 0;
`ifdef PL_DOWN_TIMER_RELOAD_EN
      for (int k = 1; k <= 256; k++) begin
         #1;
         exp_lo_tz = (k % 16 == 0);
         exp_hi_out = 15 - (k - 1) / 16;
         exp_hi_tz = (k == 256);
         if (lo_tz != exp_lo_tz || int'(hi_out) != exp_hi_out || hi_tz != exp_hi_tz) errs++;
         if (hi_tz && first_hi_tz == 0) first_hi_tz = k;
         @(negedge clk);
      end
      chk("casc_first_hi_tz", first_hi_tz, 256);
`else
      for (int k = 1; k <= 40; k++) begin
         #1;
         exp_lo_tz = (k == 16);
         exp_hi_out = (k <= 16) ? 15 : 14;
         if (lo_tz != exp_lo_tz || int'(hi_out) != exp_hi_out || hi_tz != 1'b0 ||
             lo_done != (k >= 17)) errs++;
         @(negedge clk);
      end
      chk("casc_hi_out_final", int'(hi_out), 14);
`endif
      chk("casc_errors", errs, 0);
      $display("cascade checked");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
